// File: rtl/vga_sync_decoder_if.sv
// Signal bundle between a VGA source/bench (master) and the sync decoder (slave).
// Inputs carry the sampled stream and capture coordinate; outputs carry recovered timing.
interface vga_sync_decoder_if;
  logic        hsync_in;
  logic        vsync_in;
  logic [3:0]  r_in;
  logic [3:0]  g_in;
  logic [3:0]  b_in;
  logic [9:0]  sample_x;
  logic [9:0]  sample_y;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid;
  logic [3:0]  pix_r;
  logic [3:0]  pix_g;
  logic [3:0]  pix_b;
  logic        locked;
  logic [9:0]  line_len;
  logic [9:0]  frame_lines;
  logic        h_err;
  logic        v_err;
  logic        frame_start;
  logic [11:0] sample_rgb;
  logic        sample_valid;

  modport master (
    output hsync_in, vsync_in, r_in, g_in, b_in, sample_x, sample_y,
    input  pix_x, pix_y, pix_valid, pix_r, pix_g, pix_b, locked, line_len,
           frame_lines, h_err, v_err, frame_start, sample_rgb, sample_valid
  );

  modport slave (
    input  hsync_in, vsync_in, r_in, g_in, b_in, sample_x, sample_y,
    output pix_x, pix_y, pix_valid, pix_r, pix_g, pix_b, locked, line_len,
           frame_lines, h_err, v_err, frame_start, sample_rgb, sample_valid
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, lock and line/frame measurements from a VGA stream,
// and captures the colour at one programmable coordinate per frame.
//
// state   | meaning
// LK_NONE | no clean frame since reset or last error
// LK_ONE  | one clean frame seen
// LK_OK   | two or more clean frames, locked
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic clk,
  input  logic rst,
  vga_sync_decoder_if.slave bus
);

  localparam logic [9:0]  H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0]  H_LEN   = 10'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_ONE  = 2'd1,
    LK_OK   = 2'd2
  } lock_state_t;

  logic        hs_d1_q, hs_d2_q, vs_d1_q, vs_d2_q;
  logic [11:0] rgb_d1_q;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        v_arm_q, v_arm_d;
  logic        line_seen_q, frame_seen_q;
  logic        herr_seen_q, herr_seen_d;
  lock_state_t lock_q, lock_d;

  logic [9:0]  pix_x_q, pix_y_q;
  logic [11:0] pix_rgb_q;
  logic        pix_valid_q;
  logic [9:0]  line_len_q, frame_lines_q;
  logic        h_err_q, v_err_q, frame_start_q;
  logic [11:0] sample_rgb_q;
  logic        sample_valid_q;

  logic        hfall, vfall, restart;
  logic [10:0] v_len;
  logic        frame_bad, h_err_d, v_err_d;
  logic        active, pix_en, hit;
  logic [9:0]  px, py;

  always_comb begin
    hfall     = hs_d2_q & ~hs_d1_q;
    vfall     = vs_d2_q & ~vs_d1_q;
    restart   = hfall & (v_arm_q | vfall);
    v_len     = {1'b0, v_cnt_q} + 11'd1;
    frame_bad = (v_len != V_LEN);
    // Timeout fires on the edge that takes h_cnt to its saturation value, so only once.
    h_err_d   = (hfall & line_seen_q & (h_cnt_q != H_LEN)) |
                (~hfall & (h_cnt_q == 10'd1022));
    v_err_d   = restart & frame_seen_q & frame_bad;

    h_cnt_d = hfall ? 10'd1 : ((&h_cnt_q) ? h_cnt_q : h_cnt_q + 10'd1);

    v_cnt_d = v_cnt_q;
    if (restart) begin
      v_cnt_d = 10'd0;
    end else if (hfall && !(&v_cnt_q)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end

    v_arm_d     = restart ? 1'b0 : (vfall | v_arm_q);
    herr_seen_d = restart ? 1'b0 : (herr_seen_q | h_err_d);

    lock_d = lock_q;
    if (h_err_d) begin
      lock_d = LK_NONE;
    end else if (restart && frame_seen_q) begin
      if (frame_bad || herr_seen_q) begin
        lock_d = LK_NONE;
      end else begin
        case (lock_q)
          LK_NONE: lock_d = LK_ONE;
          LK_ONE:  lock_d = LK_OK;
          default: lock_d = LK_OK;
        endcase
      end
    end

    px     = h_cnt_q - H_START;
    py     = v_cnt_q - V_START;
    active = (h_cnt_q >= H_START) && (h_cnt_q < H_END) &&
             (v_cnt_q >= V_START) && (v_cnt_q < V_END);
    pix_en = active && (lock_q == LK_OK);
    hit    = (px == bus.sample_x) && (py == bus.sample_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d1_q        <= 1'b1;
      hs_d2_q        <= 1'b1;
      vs_d1_q        <= 1'b1;
      vs_d2_q        <= 1'b1;
      rgb_d1_q       <= '0;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      v_arm_q        <= 1'b0;
      line_seen_q    <= 1'b0;
      frame_seen_q   <= 1'b0;
      herr_seen_q    <= 1'b0;
      lock_q         <= LK_NONE;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      pix_rgb_q      <= '0;
      pix_valid_q    <= 1'b0;
      line_len_q     <= '0;
      frame_lines_q  <= '0;
      h_err_q        <= 1'b0;
      v_err_q        <= 1'b0;
      frame_start_q  <= 1'b0;
      sample_rgb_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      hs_d1_q        <= bus.hsync_in;
      hs_d2_q        <= hs_d1_q;
      vs_d1_q        <= bus.vsync_in;
      vs_d2_q        <= vs_d1_q;
      rgb_d1_q       <= {bus.r_in, bus.g_in, bus.b_in};
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      v_arm_q        <= v_arm_d;
      line_seen_q    <= line_seen_q | hfall;
      frame_seen_q   <= frame_seen_q | restart;
      herr_seen_q    <= herr_seen_d;
      lock_q         <= lock_d;
      h_err_q        <= h_err_d;
      v_err_q        <= v_err_d;
      frame_start_q  <= restart;
      pix_valid_q    <= pix_en;
      sample_valid_q <= pix_en & hit;
      if (hfall) begin
        line_len_q <= h_cnt_q;
      end
      if (restart) begin
        frame_lines_q <= v_len[9:0];
      end
      if (pix_en) begin
        pix_x_q   <= px;
        pix_y_q   <= py;
        pix_rgb_q <= rgb_d1_q;
      end
      if (pix_en && hit) begin
        sample_rgb_q <= rgb_d1_q;
      end
    end
  end

  assign bus.pix_x        = pix_x_q;
  assign bus.pix_y        = pix_y_q;
  assign bus.pix_valid    = pix_valid_q;
  assign bus.pix_r        = pix_rgb_q[11:8];
  assign bus.pix_g        = pix_rgb_q[7:4];
  assign bus.pix_b        = pix_rgb_q[3:0];
  assign bus.locked       = (lock_q == LK_OK);
  assign bus.line_len     = line_len_q;
  assign bus.frame_lines  = frame_lines_q;
  assign bus.h_err        = h_err_q;
  assign bus.v_err        = v_err_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.sample_rgb   = sample_rgb_q;
  assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a shrunken 40x20 raster: a timing model driven by hsync
// fall distances and line counts predicts every output each cycle, plus literal anchors.
module tb_vga_sync_decoder;
  localparam int HT = 40, HSY = 4, HBK = 6, HAC = 24;
  localparam int VT = 20, VSY = 2, VBK = 3, VAC = 12;
  localparam int HST = HSY + HBK, VST = VSY + VBK;
  localparam int SX = 16, SY = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  vga_sync_decoder_if bus();

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HSY), .H_BACK(HBK), .H_ACTIVE(HAC),
    .V_TOTAL(VT), .V_SYNC(VSY), .V_BACK(VBK), .V_ACTIVE(VAC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px, py, pv, prgb, lk, ll, fl, he, ve, fs, srgb, sv;
  } exp_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state: time of last hsync fall, lines since frame restart, clean-frame run
  int   k, last_fall, vidx, clean_run;
  bit   fall_seen, varm, frame_seen, dirty, hs_prev, vs_prev;
  exp_t hold, exp_next, exp_cur;

  // event monitor
  int fs_cnt, pv_cnt, pv_frame, last_pv_frame, he_cnt, ve_cnt, sv_cnt;
  int he_ll, he_lk, ve_fl, ve_lk, first_x, first_y;
  bit first_seen;
  int lock_at_fs[16];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; last_fall = -1; vidx = 0; clean_run = 0;
    fall_seen = 0; varm = 0; frame_seen = 0; dirty = 0;
    hs_prev = 1; vs_prev = 1;
    hold = '{default: 0};
    exp_next = hold;
    exp_cur = hold;
  endtask

  task automatic model_step(input bit hs, input bit vs, input int rgb);
    int h, v;
    bit fall, vf, he, restart, act, lk_before;
    exp_t e;
    fall = hs_prev && !hs;
    vf = vs_prev && !vs;
    h = k - last_fall;
    if (h > 1023) h = 1023;
    v = vidx;
    lk_before = (clean_run >= 2);
    e = hold;
    e.pv = 0; e.he = 0; e.ve = 0; e.fs = 0; e.sv = 0;
    he = (fall && fall_seen && h != HT) || (!fall && h == 1022);
    restart = fall && (varm || vf);
    if (fall) e.ll = h;
    act = (h >= HST) && (h < HST + HAC) && (v >= VST) && (v < VST + VAC);
    if (act && lk_before) begin
      e.pv = 1; e.px = h - HST; e.py = v - VST; e.prgb = rgb;
      if (e.px == SX && e.py == SY) begin
        e.srgb = rgb; e.sv = 1;
      end
    end
    if (he) begin
      clean_run = 0; dirty = 1;
    end
    if (restart) begin
      e.fs = 1;
      e.fl = (v + 1) % 1024;
      if (frame_seen) begin
        e.ve = int'(v + 1 != VT);
        if (e.ve != 0 || dirty) clean_run = 0;
        else clean_run++;
      end
      frame_seen = 1; dirty = 0;
    end
    e.he = int'(he);
    e.lk = int'(clean_run >= 2);
    if (fall) begin
      last_fall = k; fall_seen = 1;
      if (restart) vidx = 0;
      else if (vidx < 1023) vidx++;
    end
    if (restart) varm = 0;
    else if (vf) varm = 1;
    hs_prev = hs; vs_prev = vs; k++;
    hold = e;
    exp_next = e;
  endtask

  task automatic drive(input bit hs, input bit vs, input int rgb);
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.r_in = rgb[11:8];
    bus.g_in = rgb[7:4];
    bus.b_in = rgb[3:0];
    model_step(hs, vs, rgb);
    @(negedge clk);
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                            input int vs_off, input bit rnd);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == bad_line) ? bad_len : HT;
      for (int i = 0; i < len; i++) begin
        bit hs, vs;
        int x, y, rgb;
        hs = (i >= HSY);
        vs = !((l < VSY && i >= vs_off) || (l == VSY && i < vs_off));
        x = i - HST;
        y = l - VST;
        rgb = rnd ? int'($urandom_range(0, 4095)) : int'({x[3:0], y[3:0], 4'hA});
        drive(hs, vs, rgb);
      end
    end
  endtask

  task automatic clr_mon();
    fs_cnt = 0; pv_cnt = 0; pv_frame = 0; last_pv_frame = -1;
    he_cnt = 0; ve_cnt = 0; sv_cnt = 0;
    he_ll = -1; he_lk = -1; ve_fl = -1; ve_lk = -1;
    first_x = -1; first_y = -1; first_seen = 0;
    for (int i = 0; i < 16; i++) lock_at_fs[i] = -1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_x"}, int'(bus.pix_x), 0);
    chk({tag, "_pix_y"}, int'(bus.pix_y), 0);
    chk({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
    chk({tag, "_pix_rgb"}, int'({bus.pix_r, bus.pix_g, bus.pix_b}), 0);
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_line_len"}, int'(bus.line_len), 0);
    chk({tag, "_frame_lines"}, int'(bus.frame_lines), 0);
    chk({tag, "_h_err"}, int'(bus.h_err), 0);
    chk({tag, "_v_err"}, int'(bus.v_err), 0);
    chk({tag, "_frame_start"}, int'(bus.frame_start), 0);
    chk({tag, "_sample_rgb"}, int'(bus.sample_rgb), 0);
    chk({tag, "_sample_valid"}, int'(bus.sample_valid), 0);
  endtask

  // compare process: every cycle, #1 after the rising edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("pix_valid", int'(bus.pix_valid), exp_cur.pv);
      chk("pix_x", int'(bus.pix_x), exp_cur.px);
      chk("pix_y", int'(bus.pix_y), exp_cur.py);
      chk("pix_rgb", int'({bus.pix_r, bus.pix_g, bus.pix_b}), exp_cur.prgb);
      chk("locked", int'(bus.locked), exp_cur.lk);
      chk("line_len", int'(bus.line_len), exp_cur.ll);
      chk("frame_lines", int'(bus.frame_lines), exp_cur.fl);
      chk("h_err", int'(bus.h_err), exp_cur.he);
      chk("v_err", int'(bus.v_err), exp_cur.ve);
      chk("frame_start", int'(bus.frame_start), exp_cur.fs);
      chk("sample_rgb", int'(bus.sample_rgb), exp_cur.srgb);
      chk("sample_valid", int'(bus.sample_valid), exp_cur.sv);
      if (bus.frame_start) begin
        fs_cnt++;
        if (fs_cnt < 16) lock_at_fs[fs_cnt] = int'(bus.locked);
        last_pv_frame = pv_frame;
        pv_frame = 0;
      end
      if (bus.pix_valid) begin
        pv_frame++; pv_cnt++;
        if (!first_seen) begin
          first_seen = 1; first_x = int'(bus.pix_x); first_y = int'(bus.pix_y);
        end
      end
      if (bus.h_err) begin
        he_cnt++; he_ll = int'(bus.line_len); he_lk = int'(bus.locked);
      end
      if (bus.v_err) begin
        ve_cnt++; ve_fl = int'(bus.frame_lines); ve_lk = int'(bus.locked);
      end
      if (bus.sample_valid) sv_cnt++;
      exp_cur = exp_next;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=%0t required=end_of_test", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.r_in = 4'h0;
    bus.g_in = 4'h0;
    bus.b_in = 4'h0;
    bus.sample_x = 10'(SX);
    bus.sample_y = 10'(SY);
    model_reset();
    clr_mon();
    #2 rst = 1'b1;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // nominal stream: lock on the third frame_start, full active area per frame
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    chk("nom_lock_fs1", lock_at_fs[1], 0);
    chk("nom_lock_fs2", lock_at_fs[2], 0);
    chk("nom_lock_fs3", lock_at_fs[3], 1);
    chk("nom_pv_per_frame", last_pv_frame, HAC * VAC);
    chk("nom_first_x", first_x, 0);
    chk("nom_first_y", first_y, 0);
    chk("nom_sample_cnt", sv_cnt, 2);
    chk("nom_sample_rgb", int'(bus.sample_rgb), 12'h08A);
    chk("nom_h_err_cnt", he_cnt, 0);
    chk("nom_v_err_cnt", ve_cnt, 0);

    // one short line, then relock after two clean frames
    clr_mon();
    send_frame(VT, 10, HT - 1, 0, 1'b0);
    chk("short_h_err_cnt", he_cnt, 1);
    chk("short_line_len", he_ll, HT - 1);
    chk("short_locked", he_lk, 0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    chk("short_lock_fs1", lock_at_fs[1], 1);
    chk("short_lock_fs2", lock_at_fs[2], 0);
    chk("short_lock_fs3", lock_at_fs[3], 0);
    chk("short_lock_fs4", lock_at_fs[4], 1);

    // one long frame
    clr_mon();
    send_frame(VT + 1, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    chk("long_v_err_cnt", ve_cnt, 1);
    chk("long_frame_lines", ve_fl, VT + 1);
    chk("long_locked", ve_lk, 0);
    chk("long_h_err_cnt", he_cnt, 0);
    chk("long_lock_fs4", lock_at_fs[4], 1);

    // randomized colours, vsync phase, line and frame lengths
    for (int f = 0; f < 10; f++) begin
      int nl, bl, blen, voff;
      nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(VT - 1, VT + 1)) : VT;
      bl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      blen = int'($urandom_range(HT - 4, HT + 4));
      voff = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, HT - 5));
      send_frame(nl, bl, blen, voff, 1'b1);
    end
    send_frame(VT, -1, 0, 0, 1'b1);

    // hsync stuck high
    clr_mon();
    repeat (1100) drive(1'b1, 1'b1, int'($urandom_range(0, 4095)));
    chk("stuck_h_err_cnt", he_cnt, 1);
    chk("stuck_pix_valid_cnt", pv_cnt, 0);
    chk("stuck_locked", int'(bus.locked), 0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);

    // reset mid-frame
    send_frame(8, -1, 0, 0, 1'b0);
    chk_en = 1'b0;
    rst = 1'b1;
    #1 chk_zero("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clr_mon();
    chk_en = 1'b1;
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    send_frame(VT, -1, 0, 0, 1'b0);
    chk("relock_fs1", lock_at_fs[1], 0);
    chk("relock_fs2", lock_at_fs[2], 0);
    chk("relock_fs3", lock_at_fs[3], 1);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the team's VGA timing generator. Samples a 4:4:4 RGB stream with Hsync/Vsync in the same pixel-clock domain and recovers pixel coordinates, a pixel-valid strobe and a lock indication. It also measures line and frame lengths and flags timing errors. It sits in loopback and bench paths downstream of the display generator and captures one programmable pixel per frame for self-check.

## Interface
Parameters:
- H_TOTAL, 800: clocks per line
- H_SYNC, 96: Hsync low width
- H_BACK, 48: clocks from Hsync end to first active pixel
- H_ACTIVE, 640: active pixels per line
- V_TOTAL, 525: lines per frame
- V_SYNC, 2: Vsync low width, in lines
- V_BACK, 33: lines from Vsync end to first active line
- V_ACTIVE, 480: active lines per frame

Ports:
- clk  in  1  pixel clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- hsync_in, vsync_in  in  1  active-low syncs
- r_in, g_in, b_in  in  4  pixel colour
- sample_x, sample_y  in  10  capture coordinate, static during use
- pix_x, pix_y  out  10  active-area coordinate
- pix_valid  out  1  pixel is in the active area and the decoder is locked
- pix_r, pix_g, pix_b  out  4  colour aligned to pix_x/pix_y
- locked  out  1  timing stable
- line_len  out  10  last measured line length
- frame_lines  out  10  last measured frame length
- h_err, v_err  out  1  one-cycle error pulses
- frame_start  out  1  one-cycle pulse at line 0 of each frame
- sample_rgb  out  12  {r,g,b} captured at the capture coordinate
- sample_valid  out  1  one-cycle pulse when sample_rgb updates

## Operation
- Input stage: hsync/vsync/rgb are registered into stage d1, and syncs additionally into d2. hfall = d2 & ~d1 on hsync; vfall is the same on vsync.
- h_cnt is 10 bits and holds the in-line index of the d1 sample. The first low hsync sample is index 0.
  - On hfall: line_len <= h_cnt; h_cnt <= 1.
  - Otherwise h_cnt increments and saturates at 1023.
- Line check: on hfall with line_seen set, h_err pulses if h_cnt != H_TOTAL. The first hfall after reset only sets line_seen.
- Line timeout: h_cnt reaching 1023 pulses h_err once and clears lock.
- Vertical counting:
  - vfall sets v_arm.
  - On an hfall with v_arm set, or with vfall coincident: frame_lines <= v_cnt+1; v_cnt <= 0; v_arm clears; frame_start pulses.
  - On any other hfall: v_cnt <= v_cnt+1, saturating at 1023.
- Frame check: at each frame restart with frame_seen set, v_err pulses if v_cnt+1 != V_TOTAL. The first restart only sets frame_seen.
- Lock state, lock_cnt 0..2; locked = (lock_cnt == 2):
  - A frame is clean if there was no h_err since the previous restart and the frame length is correct.
  - A clean frame at restart increments lock_cnt, saturating at 2.
  - A frame restart with an error sets lock_cnt to 0.
  - Any h_err sets lock_cnt to 0 immediately.
- Active area: h_cnt in [H_SYNC+H_BACK, +H_ACTIVE) and v_cnt in [V_SYNC+V_BACK, +V_ACTIVE).
  - Registered outputs: pix_x = h_cnt-(H_SYNC+H_BACK), pix_y = v_cnt-(V_SYNC+V_BACK), pix_rgb = rgb_d1, pix_valid = active & locked.
  - pix_x/pix_y/pix_rgb hold their last values when not valid.
- Capture: if active & locked and the coordinate equals sample_x/sample_y, sample_rgb <= {r,g,b}_d1 and sample_valid pulses, at the same edge as the pix outputs.

## Timing
- Reset values:
  - All outputs 0, including locked, pix_valid, all pulses, line_len, frame_lines and sample_rgb.
  - Internal state also clears: d1/d2 syncs to 1; h_cnt, v_cnt, v_arm, line_seen, frame_seen and lock_cnt to 0.
- Pixel latency: an input sample at edge k appears on pix_* after edge k+1 (2 edges).
- h_err, v_err and frame_start assert one edge after the hfall cycle and last exactly 1 cycle.
- Simultaneous events:
  - vfall coincident with hfall restarts the frame on that hfall.
  - h_err and a frame restart on the same edge: lock_cnt goes to 0.
- Reset mid-frame: all state clears. Relock needs the first restart (sets frame_seen) plus two clean frames.

## Test plan
- Nominal 800×525 stream, 4 frames: no h_err/v_err; locked rises with the 3rd frame_start. The input sample at line 35, index 144 yields pix_valid=1, pix_x=0, pix_y=0 two edges later. pix_valid is high for exactly 640×480 cycles per frame.
- One 799-clock line mid-frame: h_err pulse, line_len=799, locked=0 the next cycle. locked reasserts after two clean frames.
- One 526-line frame: v_err pulse, frame_lines=526, locked drops; no h_err.
- Pattern r=x[3:0], g=y[3:0], b=4'hA with sample=(320,240): sample_valid pulses once per locked frame with sample_rgb=12'h00A.
- hsync held high for 1100 clocks: a single h_err at h_cnt=1023, h_cnt holds at 1023, pix_valid stays 0.
- rst asserted at line 200 for 3 clocks: all outputs 0 immediately. After release, locked returns at the third subsequent frame_start.
